memory_region_unit: RTL and testbench
=====================================

Name: memory_region_unit

Overview:
Parametrised successor to the fixed two-port memory map. It serves NUM_CH independent address-lookup channels (imem, dmem, and others). Each channel resolves an address against a programmable region table and returns cacheable and fault attributes through a registered valid/ready stage. A sticky fault register captures the first faulting access for the trap/CSR logic.

Parameters:
ADDR_WIDTH, 32, address width.
TAG_WIDTH, 10, top address bits compared against the region tag (tag = addr[ADDR_WIDTH-1 -: TAG_WIDTH]).
NUM_REGIONS, 4, region table entries; IDX_W = max(1, clog2(NUM_REGIONS)).
NUM_CH, 2, lookup channels (ch0 = imem, ch1 = dmem); CH_W = max(1, clog2(NUM_CH)).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NUM_CH  per-channel request valid.
req_ready  out  NUM_CH  per-channel request ready.
req_addr  in  NUM_CH*ADDR_WIDTH  request addresses, channel c at [c*ADDR_WIDTH +: ADDR_WIDTH].
req_write  in  NUM_CH  access is a store.
req_exec  in  NUM_CH  access is an instruction fetch.
rsp_valid  out  NUM_CH  response valid.
rsp_ready  in  NUM_CH  response accepted.
rsp_cacheable  out  NUM_CH  matched region is cacheable.
rsp_fault  out  NUM_CH  access faulted.
cfg_we  in  1  region table write strobe.
cfg_idx  in  IDX_W  entry to write.
cfg_tag  in  TAG_WIDTH  new tag.
cfg_attr  in  4  {valid, X, W, C}.
fault_valid  out  1  sticky fault present.
fault_addr  out  ADDR_WIDTH  address of captured fault.
fault_ch  out  CH_W  channel of captured fault.
fault_clr  in  1  clears sticky fault.

Behaviour:
- Reset table: entry0 tag 0x0 attr 1111; entry1 tag 0x1 attr 1010 (uncached MMIO, writable, no exec); entry2 tag 0x2 attr 1111; entries >=3 attr 0000, tag 0.
- Reset outputs: rsp_valid 0, rsp_cacheable 0, rsp_fault 0, fault_valid 0, fault_addr 0, fault_ch 0. req_ready is 1 for every channel, because it is combinational from rsp_valid.
- Lookup: a match is an entry with valid=1 whose tag equals the address tag. If several entries match, the lowest index wins.
- Fault if there is no match, or req_write with W=0, or req_exec with X=0. On a fault, rsp_cacheable is 0.
- Per-channel one-entry pipeline stage:
  - req_ready[c] = !rsp_valid[c] || rsp_ready[c].
  - A request is accepted when req_valid & req_ready. The response registers load on the next edge, so latency is 1 cycle.
  - While rsp_valid is high and rsp_ready is low, the response holds stable.
  - rsp_valid falls after a handshake only if no new request is accepted in the same cycle.
  - Channels are fully independent. No combinational path from req_* to rsp_*.
- Config writes take effect on the edge following cfg_we. A lookup accepted in the same cycle as the write uses the old table contents. A cfg_idx >= NUM_REGIONS is ignored.
- Sticky fault:
  - Captured on the accept edge of a faulting request, only when fault_valid=0 (first fault wins).
  - If several channels fault in the same cycle, the lowest channel index is captured.
  - fault_clr with no new fault: fault_valid goes to 0 next edge; fault_addr and fault_ch hold their values.
  - fault_clr with a new fault in the same cycle: the new fault is captured and fault_valid stays 1.
- Asynchronous reset mid-operation: drops all in-flight responses without completion and restores the reset table immediately.
- All tag compares are unsigned and exact width. Address bits below the tag are ignored.

Test Plan:
- Post-reset fetch: ch0 addr 0x0000_1000, exec=1 -> one cycle later rsp_valid=1, cacheable=1, fault=0.
- MMIO store: ch1 addr 0x0040_0010, write=1 -> rsp cacheable=0, fault=0. Exec on ch0 at 0x0040_0000 -> fault=1, fault_addr=0x0040_0000, fault_ch=0.
- Unmapped address: ch1 addr 0x0100_0000 -> fault=1. A second fault at 0x0200_0000 leaves fault_addr unchanged. fault_clr, then a third fault at 0x0300_0000 -> captures 0x0300_0000.
- Backpressure: hold rsp_ready[1]=0 across 3 cycles with req_valid=1 -> req_ready[1]=0 and the response is stable. Release rsp_ready -> the queued request issues with no loss or duplication.
- Reprogramming: cfg_we entry3 tag 0x3FF attr 1001 in the same cycle as a lookup of 0xFFC0_0000 -> that lookup faults, the next lookup gives cacheable=1, and a write to it faults.
- Simultaneous: both channels fault in one cycle with fault_valid=0 -> fault_ch=0. Assert reset mid-stall -> rsp_valid=0 and entry3 is invalid again.

Source files
------------

// File: rtl/memory_region_unit.sv
// rtl/memory_region_unit.sv - per-channel region lookup with registered response and sticky fault capture
module memory_region_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int TAG_WIDTH   = 10,
  parameter int NUM_REGIONS = 4,
  parameter int NUM_CH      = 2,
  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CH-1:0]            req_write,
  input  logic [NUM_CH-1:0]            req_exec,
  output logic [NUM_CH-1:0]            rsp_valid,
  input  logic [NUM_CH-1:0]            rsp_ready,
  output logic [NUM_CH-1:0]            rsp_cacheable,
  output logic [NUM_CH-1:0]            rsp_fault,
  input  logic                         cfg_we,
  input  logic [IDX_W-1:0]             cfg_idx,
  input  logic [TAG_WIDTH-1:0]         cfg_tag,
  input  logic [3:0]                   cfg_attr,
  output logic                         fault_valid,
  output logic [ADDR_WIDTH-1:0]        fault_addr,
  output logic [CH_W-1:0]              fault_ch,
  input  logic                         fault_clr
);

  // attr bits: [3] valid, [2] exec allowed, [1] write allowed, [0] cacheable
  logic [TAG_WIDTH-1:0] tag_q  [NUM_REGIONS];
  logic [3:0]           attr_q [NUM_REGIONS];

  logic [NUM_CH-1:0] rsp_valid_q, rsp_cacheable_q, rsp_fault_q;
  logic [NUM_CH-1:0] accept, lk_fault, lk_cacheable;

  logic                  fault_valid_q, fault_valid_d;
  logic [ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic [CH_W-1:0]       fault_ch_q, fault_ch_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGIONS; r++) begin
        tag_q[r]  <= (r < 3) ? TAG_WIDTH'(r) : '0;
        attr_q[r] <= (r == 0 || r == 2) ? 4'b1111 : (r == 1) ? 4'b1010 : 4'b0000;
      end
    end else if (cfg_we) begin
      // Out-of-range indices match no entry and are dropped.
      for (int r = 0; r < NUM_REGIONS; r++) begin
        if (cfg_idx == IDX_W'(r)) begin
          tag_q[r]  <= cfg_tag;
          attr_q[r] <= cfg_attr;
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [TAG_WIDTH-1:0] tag;
    logic                 hit;
    logic [3:0]           hit_attr;

    assign tag = req_addr[c*ADDR_WIDTH + ADDR_WIDTH - TAG_WIDTH +: TAG_WIDTH];

    // Descending scan so the lowest matching index ends up selected.
    always_comb begin
      hit      = 1'b0;
      hit_attr = 4'b0000;
      for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
        if (attr_q[r][3] && tag_q[r] == tag) begin
          hit      = 1'b1;
          hit_attr = attr_q[r];
        end
      end
    end

    assign lk_fault[c]     = !hit || (req_write[c] && !hit_attr[1]) || (req_exec[c] && !hit_attr[2]);
    assign lk_cacheable[c] = !lk_fault[c] && hit_attr[0];
    assign req_ready[c]    = !rsp_valid_q[c] || rsp_ready[c];
    assign accept[c]       = req_valid[c] && req_ready[c];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rsp_valid_q[c]     <= 1'b0;
        rsp_cacheable_q[c] <= 1'b0;
        rsp_fault_q[c]     <= 1'b0;
      end else if (accept[c]) begin
        rsp_valid_q[c]     <= 1'b1;
        rsp_cacheable_q[c] <= lk_cacheable[c];
        rsp_fault_q[c]     <= lk_fault[c];
      end else if (rsp_ready[c]) begin
        rsp_valid_q[c]     <= 1'b0;
      end
    end
  end

  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_addr_d  = fault_addr_q;
    fault_ch_d    = fault_ch_q;
    if (fault_clr) fault_valid_d = 1'b0;
    if (!fault_valid_q || fault_clr) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (accept[c] && lk_fault[c]) begin
          fault_valid_d = 1'b1;
          fault_addr_d  = req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
          fault_ch_d    = CH_W'(c);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_ch_q    <= '0;
    end else begin
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
      fault_ch_q    <= fault_ch_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_cacheable = rsp_cacheable_q;
  assign rsp_fault     = rsp_fault_q;
  assign fault_valid   = fault_valid_q;
  assign fault_addr    = fault_addr_q;
  assign fault_ch      = fault_ch_q;

endmodule

// File: tb/tb_memory_region_unit.sv
// tb/tb_memory_region_unit.sv - directed self-checking bench for memory_region_unit
module tb_memory_region_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_write, req_exec;
  logic [63:0] req_addr;
  logic [1:0]  rsp_valid, rsp_ready, rsp_cacheable, rsp_fault;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [9:0]  cfg_tag;
  logic [3:0]  cfg_attr;
  logic        fault_valid, fault_ch, fault_clr;
  logic [31:0] fault_addr;

  int checks = 0;
  int errors = 0;

  memory_region_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_exec(req_exec),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_cacheable(rsp_cacheable), .rsp_fault(rsp_fault),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_tag(cfg_tag), .cfg_attr(cfg_attr),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_ch(fault_ch),
    .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int ch, input logic [31:0] addr, input logic wr, input logic ex);
    req_valid[ch]          = 1'b1;
    req_addr[ch*32 +: 32]  = addr;
    req_write[ch]          = wr;
    req_exec[ch]           = ex;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_write = '0; req_exec = '0; req_addr = '0;
    rsp_ready = 2'b11; cfg_we = 1'b0; cfg_idx = '0; cfg_tag = '0; cfg_attr = '0;
    fault_clr = 1'b0;
    step();
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_cacheable", 64'(rsp_cacheable), 64'd0);
    check("rst_rsp_fault", 64'(rsp_fault), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd3);
    check("rst_fault_valid", 64'(fault_valid), 64'd0);
    check("rst_fault_addr", 64'(fault_addr), 64'd0);
    check("rst_fault_ch", 64'(fault_ch), 64'd0);
    rst_n = 1'b1;
    step();

    // Post-reset fetch on ch0
    req(0, 32'h0000_1000, 1'b0, 1'b1);
    step();
    req_valid = '0;
    check("fetch_valid", 64'(rsp_valid), 64'd1);
    check("fetch_cacheable", 64'(rsp_cacheable[0]), 64'd1);
    check("fetch_fault", 64'(rsp_fault[0]), 64'd0);
    step();
    check("fetch_drain", 64'(rsp_valid), 64'd0);

    // MMIO store on ch1
    req(1, 32'h0040_0010, 1'b1, 1'b0);
    step();
    req_valid = '0;
    check("mmio_valid", 64'(rsp_valid), 64'd2);
    check("mmio_cacheable", 64'(rsp_cacheable[1]), 64'd0);
    check("mmio_fault", 64'(rsp_fault[1]), 64'd0);
    check("mmio_no_sticky", 64'(fault_valid), 64'd0);

    // Exec from MMIO on ch0
    req(0, 32'h0040_0000, 1'b0, 1'b1);
    step();
    req_valid = '0;
    check("xmmio_fault", 64'(rsp_fault[0]), 64'd1);
    check("xmmio_cacheable", 64'(rsp_cacheable[0]), 64'd0);
    check("xmmio_fv", 64'(fault_valid), 64'd1);
    check("xmmio_faddr", 64'(fault_addr), 64'h0040_0000);
    check("xmmio_fch", 64'(fault_ch), 64'd0);

    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("clr_fv", 64'(fault_valid), 64'd0);
    check("clr_faddr_hold", 64'(fault_addr), 64'h0040_0000);

    // Unmapped, then second fault ignored
    req(1, 32'h0100_0000, 1'b0, 1'b0);
    step();
    check("unmap_fault", 64'(rsp_fault[1]), 64'd1);
    check("unmap_faddr", 64'(fault_addr), 64'h0100_0000);
    check("unmap_fch", 64'(fault_ch), 64'd1);
    req(1, 32'h0200_0000, 1'b0, 1'b0);
    step();
    req_valid = '0;
    check("second_fault_rsp", 64'(rsp_fault[1]), 64'd1);
    check("second_fault_kept", 64'(fault_addr), 64'h0100_0000);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    req(1, 32'h0300_0000, 1'b0, 1'b0);
    step();
    req_valid = '0;
    check("third_fault_addr", 64'(fault_addr), 64'h0300_0000);
    check("third_fault_fv", 64'(fault_valid), 64'd1);

    // Clear and new fault in the same cycle
    fault_clr = 1'b1;
    req(0, 32'h0500_0000, 1'b0, 1'b0);
    step();
    fault_clr = 1'b0;
    req_valid = '0;
    check("clr_new_fv", 64'(fault_valid), 64'd1);
    check("clr_new_faddr", 64'(fault_addr), 64'h0500_0000);
    check("clr_new_fch", 64'(fault_ch), 64'd0);
    step();

    // Backpressure on ch1
    rsp_ready[1] = 1'b0;
    req(1, 32'h0000_2000, 1'b0, 1'b0);
    step();
    req(1, 32'h0040_0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_ready_low", 64'(req_ready[1]), 64'd0);
      check("bp_valid_hold", 64'(rsp_valid[1]), 64'd1);
      check("bp_cacheable_hold", 64'(rsp_cacheable[1]), 64'd1);
      step();
    end
    rsp_ready[1] = 1'b1;
    #1;
    check("bp_ready_release", 64'(req_ready[1]), 64'd1);
    step();
    req_valid = '0;
    check("bp_b_valid", 64'(rsp_valid[1]), 64'd1);
    check("bp_b_cacheable", 64'(rsp_cacheable[1]), 64'd0);
    check("bp_b_fault", 64'(rsp_fault[1]), 64'd0);
    step();
    check("bp_no_dup", 64'(rsp_valid[1]), 64'd0);

    // Reprogram entry3 concurrent with a lookup that must see the old table
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_tag = 10'h3FF; cfg_attr = 4'b1001;
    req(0, 32'hFFC0_0000, 1'b0, 1'b0);
    step();
    cfg_we = 1'b0;
    check("reprog_old_fault", 64'(rsp_fault[0]), 64'd1);
    check("reprog_first_wins", 64'(fault_addr), 64'h0500_0000);
    step();
    check("reprog_new_fault", 64'(rsp_fault[0]), 64'd0);
    check("reprog_new_cache", 64'(rsp_cacheable[0]), 64'd1);
    req(0, 32'hFFC0_0000, 1'b1, 1'b0);
    step();
    req_valid = '0;
    check("reprog_wr_fault", 64'(rsp_fault[0]), 64'd1);

    // Simultaneous faults
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("sim_pre_clr", 64'(fault_valid), 64'd0);
    req(0, 32'h0500_0000, 1'b0, 1'b0);
    req(1, 32'h0600_0000, 1'b0, 1'b0);
    step();
    req_valid = '0;
    check("sim_rsp_fault", 64'(rsp_fault), 64'd3);
    check("sim_fch", 64'(fault_ch), 64'd0);
    check("sim_faddr", 64'(fault_addr), 64'h0500_0000);
    step();

    // Reset mid-stall
    rsp_ready = 2'b00;
    req(0, 32'h0000_1000, 1'b0, 1'b0);
    step();
    req_valid = '0;
    check("stall_valid", 64'(rsp_valid[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(rsp_valid), 64'd0);
    check("midrst_fv", 64'(fault_valid), 64'd0);
    #1;
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    step();
    req(0, 32'hFFC0_0000, 1'b0, 1'b0);
    step();
    req_valid = '0;
    check("midrst_entry3_invalid", 64'(rsp_fault[0]), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
